seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Eight-digit, time-multiplexed 7-segment display driver.
- Sits directly downstream of the display-rate clock divider and consumes its slow square wave (scan_clk_i) as a scan-rate reference.
- Runs entirely in the system clk domain: samples scan_clk_i and advances one digit per rising edge.
- Double-buffers the displayed value and commits new data only at frame boundaries, so the display never tears.

Parameters:
- AN_ACTIVE_LOW, 1, 1 = digit-select outputs are active-low; 0 = active-high.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- scan_clk_i  in  1  slow square wave from the display clock divider; asynchronous to clk, treated as such
- data_i  in  32  eight hex nibbles; nibble k = data_i[4k+3:4k] drives digit k; digit 0 is rightmost
- dp_i  in  8  decimal point per digit, 1 = lit
- digit_en_i  in  8  per-digit enable, 1 = shown
- load_i  in  1  one-cycle strobe; captures data_i, dp_i and digit_en_i into the pending buffer
- pending_o  out  1  high while a loaded value awaits commit
- frame_o  out  1  one-cycle pulse on each commit/frame wrap
- seg_an_o  out  8  digit select; bit k selects digit k
- seg_o  out  8  segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async, rst_n=0):
  - Scan index idx=0; pending and display buffers cleared to 0; pending_o=0; frame_o=0.
  - seg_an_o all inactive (8'hFF when AN_ACTIVE_LOW=1); seg_o all off (8'hFF when SEG_ACTIVE_LOW=1).
  - Synchronizer flops cleared.
  - Reset asserted mid-frame or mid-load discards all pending state; there is no partial commit.
- Tick generation:
  - 2-flop synchronizer s1, s2 plus history flop s3 on scan_clk_i; tick = s2 & ~s3.
  - Exactly one tick per scan_clk_i rising edge, one clk wide.
  - idx advances on the 3rd clk edge after scan_clk_i rises.
  - Falling edges do nothing.
- Scan:
  - On tick, idx <= idx+1 (3-bit; 7 wraps to 0).
  - seg_an_o and seg_o are registered and reflect the new idx one clk after idx updates.
  - Only the bit for idx is active in seg_an_o.
- Decode: active-high hex table, then inverted per SEG_ACTIVE_LOW:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp bit = display dp[idx].
- Disabled digit (display digit_en[idx]=0): that slot's anode stays inactive and all segments are off for that scan slot.
- Load:
  - load_i=1 writes the pending buffer and sets pending_o the next clk.
  - Repeated loads before a commit overwrite; the last load wins.
- Commit:
  - Occurs on a tick with idx==7 (the wrap to 0).
  - If pending_o=1, display buffer <= pending buffer and pending_o <= 0.
  - frame_o pulses on every wrap, whether or not a commit happens.
- Simultaneous load_i and commit tick:
  - The commit takes the old pending contents.
  - The pending buffer takes the new data.
  - pending_o stays 1, so the new data commits at the next wrap.
- Worst-case load-to-visible latency: 8 ticks + 1 clk.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: enabled digits above the most-significant nonzero nibble of the display buffer are blanked (anode inactive, segments off). Digit 0 is always shown, so value 0 displays a single "0". dp_i does not prevent blanking.
- Undefined: every enabled digit is shown, including leading zeros.

Test Plan:
- Reset then scan_clk_i toggling with no load -> all eight slots show digit "0": seg_o=8'hC0, seg_an_o cycles FE, FD, FB, ... 7F; pending_o=0.
- load_i with data_i=32'h1234ABCD, dp_i=8'h01, digit_en_i=8'hFF at idx=3 -> pending_o=1 until the wrap tick, then frame_o pulses. Next frame, slot 0 shows seg_o=8'h21 ("d" with dp lit, active-low) and slot 7 shows 8'hF9 ("1").
- Two loads in one frame (32'h11111111, then 32'h22222222) -> only 22222222 is ever displayed.
- load_i asserted in the same cycle as the idx==7 tick -> the prior pending value is displayed for one frame, the new value in the following frame; pending_o stays high across the wrap.
- digit_en_i=8'h0F -> seg_an_o never activates bits 7..4 and seg_o is 8'hFF in those slots.
- rst_n pulsed low while pending_o=1 at idx=5 -> outputs go to reset values immediately (asynchronously), pending is lost, and scanning resumes at idx=0 showing "0". With SEG7_LEADING_ZERO_BLANK_EN defined, data 32'h000000A5 lights only digits 1 and 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Eight-digit time-multiplexed 7-segment driver. The block samples the slow
//   scan_clk_i square wave in the clk domain and advances one digit per rising
//   edge. Loaded values wait in a pending buffer and are copied into the
//   display buffer only at the frame wrap (idx 7 -> 0), so a frame never shows
//   a mix of old and new data.
//
//   Optional feature, enabled by defining SEG7_LEADING_ZERO_BLANK_EN: enabled
//   digits above the most-significant nonzero nibble are blanked. Digit 0 is
//   always shown.
//
// Parameters
//   AN_ACTIVE_LOW   1: seg_an_o is active-low, 0: active-high
//   SEG_ACTIVE_LOW  1: seg_o is active-low,    0: active-high
//
// Ports
//   clk, rst_n       system clock; asynchronous active-low reset
//   scan_clk_i       scan-rate square wave, asynchronous to clk
//   data_i[31:0]     nibble k drives digit k (digit 0 is rightmost)
//   dp_i[7:0]        decimal point per digit, 1 = lit
//   digit_en_i[7:0]  per-digit enable, 1 = shown
//   load_i           strobe that captures data/dp/en into the pending buffer
//   pending_o        a loaded value is waiting for the next frame wrap
//   frame_o          one-cycle pulse on every frame wrap
//   seg_an_o[7:0]    digit select, bit k = digit k
//   seg_o[7:0]       segments {dp,g,f,e,d,c,b,a}
module seg7_scan_driver #(
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_clk_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  digit_en_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic        frame_o,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_o
);

  localparam logic [7:0] AN_OFF  = {8{AN_ACTIVE_LOW}};
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic        r_s1, r_s2, r_s3;
  logic [2:0]  r_idx;
  logic [31:0] r_pend_data, r_disp_data;
  logic [7:0]  r_pend_dp,   r_disp_dp;
  logic [7:0]  r_pend_en,   r_disp_en;
  logic        r_pending;
  logic        r_frame;
  logic [7:0]  r_an, r_seg;

  logic        w_tick, w_wrap, w_show;
  logic [3:0]  w_nib;
  logic [2:0]  w_msd;
  logic [7:0]  w_an_act, w_seg_act;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // s1/s2 synchronize; s3 is the history that turns the level into a
  // single-cycle rising-edge tick.
  assign w_tick = r_s2 & ~r_s3;
  assign w_wrap = w_tick & (r_idx == 3'd7);

  always_comb begin
    w_msd     = 3'd0;
    w_nib     = r_disp_data[r_idx*4 +: 4];
    w_show    = r_disp_en[r_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int k = 1; k < 8; k++)
      if (r_disp_data[k*4 +: 4] != 4'd0) w_msd = k[2:0];
    if (r_idx > w_msd) w_show = 1'b0;
`endif
    w_an_act  = w_show ? (8'd1 << r_idx) : 8'd0;
    w_seg_act = w_show ? {r_disp_dp[r_idx], hex7(w_nib)} : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_idx       <= 3'd0;
      r_pend_data <= 32'd0;
      r_pend_dp   <= 8'd0;
      r_disp_data <= 32'd0;
      r_disp_dp   <= 8'd0;
      // Enables come out of reset all-on so an unloaded display scans "0"
      // in every slot instead of staying dark.
      r_pend_en   <= 8'hFF;
      r_disp_en   <= 8'hFF;
      r_pending   <= 1'b0;
      r_frame     <= 1'b0;
      r_an        <= AN_OFF;
      r_seg       <= SEG_OFF;
    end else begin
      r_s1    <= scan_clk_i;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_frame <= w_wrap;
      if (w_tick) r_idx <= r_idx + 3'd1;
      // Commit reads the old pending contents even if a load lands on the
      // same cycle; that load then stays pending for the next wrap.
      if (w_wrap && r_pending) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_disp_en   <= r_pend_en;
      end
      if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
        r_pend_en   <= digit_en_i;
        r_pending   <= 1'b1;
      end else if (w_wrap) begin
        r_pending   <= 1'b0;
      end
      r_an  <= w_an_act  ^ AN_OFF;
      r_seg <= w_seg_act ^ SEG_OFF;
    end
  end

  assign pending_o = r_pending;
  assign frame_o   = r_frame;
  assign seg_an_o  = r_an;
  assign seg_o     = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver. A frame-level model (scan position,
// pending/display contents) predicts the visible digit after every scan step.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic [7:0]  digit_en_i = '0;
  logic        load_i = 1'b0;
  logic        pending_o, frame_o;
  logic [7:0]  seg_an_o, seg_o;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;

  // model state
  int          m_idx;
  logic [31:0] m_data, m_pdata;
  logic [7:0]  m_dp, m_pdp, m_en, m_pen;
  bit          m_pend;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .scan_clk_i(scan_clk_i), .data_i(data_i),
    .dp_i(dp_i), .digit_en_i(digit_en_i), .load_i(load_i),
    .pending_o(pending_o), .frame_o(frame_o), .seg_an_o(seg_an_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_o) frame_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_idx = 0; m_data = '0; m_dp = '0; m_en = 8'hFF;
    m_pdata = '0; m_pdp = '0; m_pen = 8'hFF; m_pend = 0;
  endtask

  task automatic chk_display(input string tag);
    bit shown;
    logic [7:0] ean, eseg;
    shown = m_en[m_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (m_idx != 0 && (m_data >> (4*m_idx)) == 32'd0) shown = 0;
`endif
    ean  = shown ? ~(8'h01 << m_idx) : 8'hFF;
    eseg = shown ? ~{m_dp[m_idx], hex_tab[m_data[4*m_idx +: 4]]} : 8'hFF;
    chk({tag, "_an"},  seg_an_o, ean);
    chk({tag, "_seg"}, seg_o, eseg);
    chk({tag, "_pend"}, pending_o, m_pend);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    @(negedge clk);
    load_i = 1'b1; data_i = d; dp_i = dp; digit_en_i = en;
    @(negedge clk);
    load_i = 1'b0;
    m_pdata = d; m_pdp = dp; m_pen = en; m_pend = 1;
    #1 chk("load_pend", pending_o, 1'b1);
  endtask

  // One scan_clk_i period. With lt set, load_i is held exactly in the tick cycle.
  task automatic step(input bit lt, input logic [31:0] d, input logic [7:0] dp,
                      input logic [7:0] en);
    int f0;
    bit wrap;
    f0 = frame_cnt;
    @(negedge clk) scan_clk_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    if (lt) begin
      @(negedge clk);
      load_i = 1'b1; data_i = d; dp_i = dp; digit_en_i = en;
    end
    @(posedge clk);
    @(negedge clk) load_i = 1'b0;
    wrap = (m_idx == 7);
    if (wrap && m_pend) begin
      m_data = m_pdata; m_dp = m_pdp; m_en = m_pen; m_pend = 0;
    end
    if (lt) begin
      m_pdata = d; m_pdp = dp; m_pen = en; m_pend = 1;
    end
    m_idx = (m_idx + 1) % 8;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_display("scan");
    chk("frame", frame_cnt - f0, wrap ? 1 : 0);
    scan_clk_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_idx != target && guard < 16) begin
      step(0, '0, '0, '0);
      guard++;
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", seg_an_o, 8'hFF);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_pend", pending_o, 1'b0);
    chk("rst_frame", frame_o, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_seg", seg_o, 8'hC0);
    chk("idle_an", seg_an_o, 8'hFE);

    // idle scan, all zeros
    run(8);

    // load at idx 3; commit at the wrap
    run_to(3);
    do_load(32'h1234ABCD, 8'h01, 8'hFF);
    run(9);

    // two loads in one frame: last wins
    do_load(32'h11111111, 8'h00, 8'hFF);
    do_load(32'h22222222, 8'h00, 8'hFF);
    run(10);

    // load coinciding with the wrap tick
    run_to(5);
    do_load(32'h55555555, 8'hF0, 8'hFF);
    run_to(7);
    step(1, 32'h66666666, 8'h0F, 8'hFF);
    chk("wrap_load_pend", pending_o, 1'b1);
    run(16);

    // partial enable
    do_load(32'h89ABCDEF, 8'hFF, 8'h0F);
    run(17);

    // async reset mid-frame with data pending
    run_to(5);
    do_load(32'hDEADBEEF, 8'hAA, 8'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", seg_an_o, 8'hFF);
    chk("arst_seg", seg_o, 8'hFF);
    chk("arst_pend", pending_o, 1'b0);
    chk("arst_frame", frame_o, 1'b0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_display("post_rst");
    run(8);

    // leading zero case (blanked only when the feature is built in)
    do_load(32'h000000A5, 8'h00, 8'hFF);
    run(16);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      int r;
      logic [31:0] d;
      logic [7:0] dp, en;
      r  = $urandom_range(0, 9);
      d  = $urandom >> (4 * $urandom_range(0, 7));
      dp = 8'($urandom);
      en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if (r < 2) do_load(d, dp, en);
      step(r == 2, d, dp, en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
